// File: rtl/bin_to_bcd.sv
// Binary to packed-BCD converter (double-dabble) with registered outputs.
// Define BIN2BCD_ITER_EN for the iterative one-step-per-cycle FSM build.
module bin_to_bcd #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  output logic                  overflow
);

  // ceil(BIN_W/3) digits always hold 2**BIN_W-1, since 8**k < 10**k
  localparam int NAT_D = (BIN_W + 2) / 3;
  localparam int ALL_D = (NAT_D > DIGITS) ? NAT_D : DIGITS;
  localparam int ALL_W = 4 * ALL_D;
  localparam int BCD_W = 4 * DIGITS;

  function automatic logic [ALL_W-1:0] dd_step(input logic [ALL_W-1:0] dig, input logic b);
    logic [ALL_W-1:0] t;
    t = dig;
    for (int d = 0; d < ALL_D; d++) begin
      if (t[4*d +: 4] >= 4'd5) t[4*d +: 4] = t[4*d +: 4] + 4'd3;
    end
    return {t[ALL_W-2:0], b};
  endfunction

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  assign bcd       = bcd_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;

`ifdef BIN2BCD_ITER_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [ALL_W-1:0] dig_q, dig_d;

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    dig_d       = dig_q;
    bcd_d       = bcd_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = bin;
          dig_d   = '0;
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        dig_d   = dd_step(dig_q, shreg_q[BIN_W-1]);
        shreg_d = shreg_q << 1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        bcd_d       = dig_q[BCD_W-1:0];
        ovf_d       = |(dig_q >> BCD_W);
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      dig_q       <= '0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      dig_q       <= dig_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
`else
  logic [ALL_W-1:0] dig;

  assign in_ready = 1'b1;

  always_comb begin
    dig = '0;
    for (int i = BIN_W - 1; i >= 0; i--) dig = dd_step(dig, bin[i]);
    bcd_d       = dig[BCD_W-1:0];
    ovf_d       = |(dig >> BCD_W);
    out_valid_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_bin_to_bcd.sv
// Randomized self-checking bench for bin_to_bcd (default single-cycle build),
// with a 3-digit and a 2-digit (overflow-capable) instance side by side.
module tb_bin_to_bcd;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bin = '0;
  logic        in_valid = 1'b0;

  logic        in_ready_a, out_valid_a, ovf_a;
  logic [11:0] bcd_a;
  logic        in_ready_b, out_valid_b, ovf_b;
  logic [7:0]  bcd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd #(.BIN_W(8), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bin(bin), .in_valid(in_valid),
    .in_ready(in_ready_a), .bcd(bcd_a), .out_valid(out_valid_a), .overflow(ovf_a)
  );

  bin_to_bcd #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bin(bin), .in_valid(in_valid),
    .in_ready(in_ready_b), .bcd(bcd_b), .out_valid(out_valid_b), .overflow(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // decimal digits of v modulo 10**nd, packed four bits per digit
  function automatic logic [31:0] ref_bcd(input int v, input int nd);
    int p = 1;
    logic [31:0] r = '0;
    for (int d = 0; d < nd; d++) begin
      r = r | (32'((v / p) % 10) << (4 * d));
      p = p * 10;
    end
    return r;
  endfunction

  task automatic apply_check(input int v, input logic vld, input string tag);
    bin      = 8'(v);
    in_valid = vld;
    @(posedge clk);
    #1;
    chk({tag, "_bcd3"}, 32'(bcd_a), ref_bcd(v, 3));
    chk({tag, "_ovf3"}, 32'(ovf_a), 32'(v >= 1000));
    chk({tag, "_vld3"}, 32'(out_valid_a), 32'(vld));
    chk({tag, "_bcd2"}, 32'(bcd_b), ref_bcd(v, 2));
    chk({tag, "_ovf2"}, 32'(ovf_b), 32'(v >= 100));
    chk({tag, "_vld2"}, 32'(out_valid_b), 32'(vld));
  endtask

  initial begin
    int bnd[] = '{0, 9, 10, 99, 100, 199, 200, 255, 150, 37};

    #2;
    chk("rst_bcd3", 32'(bcd_a), 32'h0);
    chk("rst_vld3", 32'(out_valid_a), 32'h0);
    chk("rst_ovf3", 32'(ovf_a), 32'h0);
    chk("rst_rdy3", 32'(in_ready_a), 32'h1);
    chk("rst_bcd2", 32'(bcd_b), 32'h0);
    chk("rst_rdy2", 32'(in_ready_b), 32'h1);

    #20 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int v = 0; v < 256; v++) apply_check(v, 1'($urandom_range(0, 1)), "sweep");
    foreach (bnd[i]) apply_check(bnd[i], 1'b1, "bnd");
    repeat (100) apply_check(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rand");

    bin      = 8'd123;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_bcd3", 32'(bcd_a), 32'h123);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_bcd3", 32'(bcd_a), 32'h0);
    chk("mid_rst_vld3", 32'(out_valid_a), 32'h0);
    chk("mid_rst_bcd2", 32'(bcd_b), 32'h0);
    chk("mid_rst_ovf2", 32'(ovf_b), 32'h0);
    chk("mid_rst_rdy3", 32'(in_ready_a), 32'h1);
    #7 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    apply_check(123, 1'b1, "post_rst");
    apply_check(77, 1'b1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
